// File: rtl/rr_arb_client.sv
// rr_arb_client: requester-side agent for a 4-way round-robin time-slice
// arbiter. Each client has a small job queue. The head entry counts down its
// remaining beats in place, so a job that loses its grant resumes where it
// stopped on the next grant. The agent reports beats, job completions and
// grant protocol errors.
module rr_arb_client #(
  parameter int NUM_CLI = 4,
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  input  logic [1:0]               job_cli,
  input  logic [LEN_W-1:0]         job_len,
  output logic                     job_ready,
  output logic [NUM_CLI-1:0]       req,
  input  logic [NUM_CLI-1:0]       gnt,
  output logic                     beat_valid,
  output logic [1:0]               beat_cli,
  output logic [NUM_CLI-1:0]       done,
  output logic [NUM_CLI*CNT_W-1:0] pending,
  output logic                     err_gnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_XFER} state_t;

  state_t            state   [NUM_CLI];
  logic [LEN_W-1:0]  mem     [NUM_CLI][DEPTH];
  logic [PTR_W-1:0]  rd_ptr  [NUM_CLI];
  logic [PTR_W-1:0]  wr_ptr  [NUM_CLI];
  logic [CNT_W-1:0]  cnt     [NUM_CLI];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CLI];
  logic [LEN_W-1:0]  head    [NUM_CLI];
  logic [NUM_CLI-1:0] push;
  logic [NUM_CLI-1:0] beat;
  logic [NUM_CLI-1:0] pop;
  logic [1:0]        beat_idx;
  logic              gnt_onehot;
  logic              grant_err;

  // A push is refused on the pre-edge occupancy, even if the head pops now.
  assign job_ready = (cnt[job_cli] != CNT_W'(DEPTH));

  // Per-client push/beat/pop decisions and next occupancy.
  always_comb begin
    gnt_onehot = $onehot0(gnt);
    // Illegal multi-hot grant blocks all beats; a grant to a non-requester is ignored.
    grant_err  = !gnt_onehot || ((gnt & ~req) != '0);
    beat_idx   = '0;
    pending    = '0;
    for (int i = 0; i < NUM_CLI; i++) begin
      // Zero-length jobs are accepted but never enter the queue.
      push[i]    = job_valid && job_ready && (job_cli == 2'(i)) && (job_len != '0);
      head[i]    = mem[i][rd_ptr[i]];
      beat[i]    = gnt_onehot && gnt[i] && (state[i] != ST_IDLE);
      pop[i]     = beat[i] && (head[i] == LEN_W'(1));
      cnt_nxt[i] = cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      if (beat[i]) beat_idx = 2'(i);
      pending[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  // Job storage: pushes write the tail, beats decrement the head in place.
  // NOTE: the queue array has no reset; pointers and counts define which
  // entries are live, so clearing those flushes the queue.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLI; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= job_len;
      if (beat[i]) mem[i][rd_ptr[i]] <= head[i] - LEN_W'(1);
    end
  end

  // Queue pointers, per-client FSM and registered status outputs.
  // NOTE: all state here uses non-blocking assignments so every client sees
  // the same pre-edge values regardless of loop order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLI; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
        state[i]  <= ST_IDLE;
      end
      req        <= '0;
      beat_valid <= 1'b0;
      beat_cli   <= '0;
      done       <= '0;
      err_gnt    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CLI; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        cnt[i] <= cnt_nxt[i];
        if (cnt_nxt[i] == '0)  state[i] <= ST_IDLE;
        else if (beat[i])      state[i] <= ST_XFER;
        else                   state[i] <= ST_WAIT;
        req[i] <= (cnt_nxt[i] != '0);
      end
      beat_valid <= |beat;
      beat_cli   <= beat_idx;
      done       <= pop;
      if (grant_err) err_gnt <= 1'b1;
    end
  end

endmodule
